lcd_button_conditioner: RTL and testbench

Conditions one raw push-button from a board pin (e.g. the LCD menu "scroll up" key) into a clean level, a one-cycle press pulse, a one-cycle release pulse and auto-repeat pulses while held. Sits directly upstream of the 1-bit Avalon PIO input slave: btn_level drives that PIO's in_port. The pulses feed local LCD control logic.

---
 rtl/lcd_io_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/lcd_button_conditioner.sv | 119 +++++++++++
 tb/tb_lcd_button_conditioner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_io_pkg.sv
// Purpose : shared types and timing defaults for the LCD board-I/O conditioning blocks.
// Latency : n/a (package only).
// Backpr. : n/a; contents are the button FSM state enum, a counter-width helper and 50 MHz timing defaults.
package lcd_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        REPEAT,
        DB_RELEASE
    } btn_state_t;

    // 50 MHz defaults: 20 ms debounce, 500 ms to first repeat, 100 ms repeat period.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_HOLD_CYCLES     = 25_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 5_000_000;

    // Width for a counter shared by all three timers: clog2 of the largest plus a spare bit.
    function automatic int cnt_width(input int unsigned a, input int unsigned b, input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose : generic 1-bit two-flop synchronizer for asynchronous board inputs.
// Latency : 2 clk edges from i_d to o_q.
// Backpr. : none; free-running. Ports: clk, reset_n (async, active-low), i_d (async in), o_q (synced out).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/lcd_button_conditioner.sv
// Purpose : debounces one raw push-button into a level plus press/release/auto-repeat pulses.
// Latency : DEBOUNCE_CYCLES+3 clk edges from a settled pin to btn_level/press_pulse (release symmetric).
// Backpr. : none; pulses are single-cycle and unacknowledged. Ports: clk, reset_n, btn_raw -> btn_level,
//           press_pulse, release_pulse, repeat_pulse (all outputs registered).
module lcd_button_conditioner
    import lcd_io_pkg::*;
#(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    logic          w_sync;
    logic          w_act;
    btn_state_t    r_state;
    btn_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_rpt_tick;
    logic          w_level_nxt;
    logic          w_press_nxt;
    logic          w_release_nxt;
    logic          w_repeat_nxt;

    // Sync flops park at the released pin level so reset never looks like a press.
    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (btn_raw),
        .o_q     (w_sync)
    );

    assign w_act = ACTIVE_LOW ? ~w_sync : w_sync;

    // State register, shared counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            btn_level     <= w_level_nxt;
            press_pulse   <= w_press_nxt;
            release_pulse <= w_release_nxt;
            repeat_pulse  <= w_repeat_nxt;
        end
    end

    // Next state. The act test comes before the terminal-count test, so an input
    // change on a terminal edge wins and suppresses that edge's pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_rpt_tick  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_act) w_state_nxt = DB_PRESS;
            end
            DB_PRESS: begin
                if (!w_act)               w_state_nxt = IDLE;
                else if (r_cnt == DB_LAST) w_state_nxt = HELD;
            end
            HELD: begin
                if (!w_act)                  w_state_nxt = DB_RELEASE;
                else if (r_cnt == HOLD_LAST) w_state_nxt = REPEAT;
            end
            REPEAT: begin
                if (!w_act) begin
                    w_state_nxt = DB_RELEASE;
                end else if (r_cnt == REP_LAST) begin
                    w_rpt_tick = 1'b1;
                    w_cnt_nxt  = '0;
                end
            end
            DB_RELEASE: begin
                // Bounce back to pressed restarts the hold timer without a new press.
                if (w_act)                 w_state_nxt = HELD;
                else if (r_cnt == DB_LAST) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    // Output decode from the transition being taken, so pulses and level move on one edge.
    always_comb begin
        w_level_nxt   = (w_state_nxt == HELD) || (w_state_nxt == REPEAT) ||
                        (w_state_nxt == DB_RELEASE);
        w_press_nxt   = (r_state == DB_PRESS)   && (w_state_nxt == HELD);
        w_release_nxt = (r_state == DB_RELEASE) && (w_state_nxt == IDLE);
        w_repeat_nxt  = ((r_state == HELD) && (w_state_nxt == REPEAT)) || w_rpt_tick;
    end

endmodule

// File: tb/tb_lcd_button_conditioner.sv
// Purpose : directed + randomized bench for lcd_button_conditioner with a run-length reference model.
// Latency : n/a.
// Backpr. : n/a.
module tb_lcd_button_conditioner;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic btn_raw = 1'b1;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int ec    = 0;
    int n_press   = 0;
    int n_release = 0;
    int n_repeat  = 0;

    always #5 clk = ~clk;

    lcd_button_conditioner #(
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    // Reference model: decisions come from the length of the current run of equal
    // pressed/released samples and the number of edges since the hold timer started.
    typedef struct packed {
        int n;
        int hs;
        int run;
        bit prev;
        bit lvl;
        bit pr;
        bit rl;
        bit rp;
    } mdl_t;

    mdl_t m;
    bit   d1;
    bit   d2;

    function automatic mdl_t model_step(input mdl_t s, input bit a);
        mdl_t t;
        t      = s;
        t.n    = s.n + 1;
        t.pr   = 1'b0;
        t.rl   = 1'b0;
        t.rp   = 1'b0;
        t.run  = (a == s.prev) ? s.run + 1 : 1;
        t.prev = a;
        if (!s.lvl) begin
            if (a && t.run == D + 1) begin
                t.lvl = 1'b1;
                t.pr  = 1'b1;
                t.hs  = t.n;
            end
        end else if (!a) begin
            if (t.run == D + 1) begin
                t.lvl = 1'b0;
                t.rl  = 1'b1;
            end
        end else if (t.run == 1) begin
            t.hs = t.n;
        end else if ((t.n - t.hs) >= H && ((t.n - t.hs - H) % R) == 0) begin
            t.rp = 1'b1;
        end
        return t;
    endfunction

    // d1/d2 mirror the two synchronizer stages: the decision at an edge uses the
    // pin as it was two edges earlier.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m  <= '0;
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            m  <= model_step(m, d2);
            d2 <= d1;
            d1 <= ~btn_raw;
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp_v, ec);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp_v, ec);
        end
    endtask

    task automatic clr_counts();
        n_press   = 0;
        n_release = 0;
        n_repeat  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ec++;
        chk("model_level",   btn_level,     m.lvl);
        chk("model_press",   press_pulse,   m.pr);
        chk("model_release", release_pulse, m.rl);
        chk("model_repeat",  repeat_pulse,  m.rp);
        n_press   += (press_pulse   === 1'b1) ? 1 : 0;
        n_release += (release_pulse === 1'b1) ? 1 : 0;
        n_repeat  += (repeat_pulse  === 1'b1) ? 1 : 0;
    endtask

    initial begin
        // 1. Reset held with the pin released.
        repeat (20) tick();
        chk("rst_level", btn_level, 1'b0);
        chk_n("rst_pulses", n_press + n_release + n_repeat, 0);

        // 2. Press settled before edge 1 -> press at edge 7.
        @(negedge clk);
        reset_n = 1'b1;
        btn_raw = 1'b0;
        ec = 0;
        clr_counts();
        repeat (6) tick();
        chk("t2_pre_level", btn_level, 1'b0);
        chk_n("t2_pre_press", n_press, 0);
        tick();
        chk("t2_level", btn_level, 1'b1);
        chk("t2_press", press_pulse, 1'b1);
        tick();
        chk("t2_press_end", press_pulse, 1'b0);

        // 4. Hold: repeat 10 edges after press, then every 3.
        while (ec < 16) tick();
        chk_n("t4_no_early_rep", n_repeat, 0);
        tick();
        chk("t4_rep1", repeat_pulse, 1'b1);
        repeat (3) tick();
        chk("t4_rep2", repeat_pulse, 1'b1);
        repeat (3) tick();
        chk("t4_rep3", repeat_pulse, 1'b1);
        btn_raw = 1'b1;
        clr_counts();
        repeat (6) tick();
        chk("t4_rel_level_hold", btn_level, 1'b1);
        tick();
        chk("t4_release", release_pulse, 1'b1);
        chk("t4_rel_level", btn_level, 1'b0);
        chk_n("t4_no_rep_after", n_repeat, 0);

        // 3. Press bounce: 0 x3, 1 x2, then 0 held; last transition before edge 36.
        btn_raw = 1'b0;
        tick();
        chk("t3_release_end", release_pulse, 1'b0);
        repeat (2) tick();
        btn_raw = 1'b1;
        repeat (2) tick();
        btn_raw = 1'b0;
        clr_counts();
        while (ec < 41) tick();
        chk_n("t3_no_early_press", n_press, 0);
        chk("t3_pre_level", btn_level, 1'b0);
        tick();
        chk("t3_press", press_pulse, 1'b1);
        chk("t3_level", btn_level, 1'b1);

        // 5. Release bounce while HELD: hold timer restarts at edge 49.
        repeat (2) tick();
        btn_raw = 1'b1;
        repeat (2) tick();
        btn_raw = 1'b0;
        clr_counts();
        while (ec < 58) tick();
        chk("t5_level", btn_level, 1'b1);
        chk_n("t5_no_release", n_release, 0);
        chk_n("t5_no_press", n_press, 0);
        chk_n("t5_no_rep", n_repeat, 0);
        tick();
        chk("t5_rep1", repeat_pulse, 1'b1);

        // 6. Async reset mid-REPEAT, then a fresh press with the pin still held.
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_level", btn_level, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        reset_n = 1'b1;
        ec = 0;
        clr_counts();
        repeat (6) tick();
        chk_n("t6_no_early_press", n_press, 0);
        tick();
        chk("t6_press", press_pulse, 1'b1);
        chk("t6_level", btn_level, 1'b1);

        // Randomized pin activity: short glitches mixed with long holds.
        repeat (60) begin
            btn_raw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(15, 30)) tick();
            else
                repeat ($urandom_range(1, 6)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
